reg_file_param: RTL and testbench

Parametrised successor to the 4x8 register file, sitting between instruction decode and the ALU in the core datapath. It provides two asynchronous read ports with same-cycle write bypass, one synchronous write port, and synchronous reset of all registers. A sequential debug dump engine streams every register out, one per cycle, on request.

---
 rtl/reg_file_param.sv | 172 +++++++++++++++++
 tb/tb_reg_file_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports with write bypass,
// one synchronous write port, and a one-register-per-cycle debug dump engine.
// Optional build macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_a,
    input  logic [ADDR_W-1:0] read_b,
    output logic [DATA_W-1:0] read_a_data,
    output logic [DATA_W-1:0] read_b_data,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DUMP = 1'b1
    } dump_state_t;

    logic [DATA_W-1:0] r_core [NUM_REGS];
    dump_state_t       r_state;
    dump_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_wr_ok;

    // Qualified write strobe; also gates the bypass so discarded writes never leak
    always_comb begin
`ifdef REG_FILE_ZERO_REG_EN
        if (write_enable && (write_addr != ZERO_IDX)) begin
            w_wr_ok = 1'b1;
        end else begin
            w_wr_ok = 1'b0;
        end
`else
        if (write_enable) begin
            w_wr_ok = 1'b1;
        end else begin
            w_wr_ok = 1'b0;
        end
`endif
    end

    // Register storage; reset has priority over a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_core[i] <= ZERO_DATA;
            end
        end else if (w_wr_ok) begin
            r_core[write_addr] <= write_data;
        end else begin
            r_core[write_addr] <= r_core[write_addr];
        end
    end

    // Read port A with same-cycle write bypass
    always_comb begin
        if (w_wr_ok && (write_addr == read_a)) begin
            read_a_data = write_data;
        end else begin
            read_a_data = r_core[read_a];
        end
`ifdef REG_FILE_ZERO_REG_EN
        if (read_a == ZERO_IDX) begin
            read_a_data = ZERO_DATA;
        end else begin
            read_a_data = read_a_data;
        end
`endif
    end

    // Read port B with same-cycle write bypass
    always_comb begin
        if (w_wr_ok && (write_addr == read_b)) begin
            read_b_data = write_data;
        end else begin
            read_b_data = r_core[read_b];
        end
`ifdef REG_FILE_ZERO_REG_EN
        if (read_b == ZERO_IDX) begin
            read_b_data = ZERO_DATA;
        end else begin
            read_b_data = read_b_data;
        end
`endif
    end

    // Dump FSM state and index counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= ZERO_IDX;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Dump FSM next state; the counter wraps to 0 on the final dumped index
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (dump_start) begin
                    w_state_nxt = S_DUMP;
                    w_cnt_nxt   = ZERO_IDX;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            S_DUMP: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DUMP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = ZERO_IDX;
            end
        endcase
    end

    // Dump outputs; dump_data is committed storage only, no bypass
    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_addr  = r_cnt;
        dump_data  = r_core[r_cnt];
        case (r_state)
            S_DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
            end
            S_IDLE: begin
                dump_valid = 1'b0;
                dump_busy  = 1'b0;
            end
            default: begin
                dump_valid = 1'b0;
                dump_busy  = 1'b0;
            end
        endcase
`ifdef REG_FILE_ZERO_REG_EN
        if (r_cnt == ZERO_IDX) begin
            dump_data = ZERO_DATA;
        end else begin
            dump_data = dump_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed scenarios followed by
// random traffic, all checked against an array-based behavioural model.
module tb_reg_file_param;

    localparam int NUM = 4;
`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [1:0] wa = 2'd0;
    logic [7:0] wd = 8'd0;
    logic [1:0] ra = 2'd0;
    logic [1:0] rb = 2'd0;
    logic       ds = 1'b0;
    logic [7:0] rad, rbd, ddata;
    logic       dbusy, dvalid;
    logic [1:0] daddr;

    int total = 0;
    int bad   = 0;

    // behavioural model: register contents and dump position (-1 = idle)
    logic [7:0] mdl [NUM];
    int         dpos = -1;

    reg_file_param #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .write_enable(we), .write_addr(wa),
        .write_data(wd), .read_a(ra), .read_b(rb), .read_a_data(rad),
        .read_b_data(rbd), .dump_start(ds), .dump_busy(dbusy),
        .dump_valid(dvalid), .dump_addr(daddr), .dump_data(ddata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stored(input int idx);
        if (ZERO && idx == 0) return 8'h00;
        else return mdl[idx];
    endfunction

    function automatic logic [7:0] exp_read(input logic [1:0] idx);
        if (ZERO && idx == 2'd0) return 8'h00;
        if (we && wa == idx && !(ZERO && wa == 2'd0)) return wd;
        return mdl[idx];
    endfunction

    // compare every observable output against the model (before the edge)
    task automatic check_all(input string tag);
        chk({tag, "_rda"}, 32'(rad), 32'(exp_read(ra)));
        chk({tag, "_rdb"}, 32'(rbd), 32'(exp_read(rb)));
        chk({tag, "_valid"}, 32'(dvalid), 32'(dpos >= 0));
        chk({tag, "_busy"}, 32'(dbusy), 32'(dpos >= 0));
        if (dpos >= 0) begin
            chk({tag, "_daddr"}, 32'(daddr), 32'(dpos));
            chk({tag, "_ddata"}, 32'(ddata), 32'(stored(dpos)));
        end else begin
            chk({tag, "_daddr_idle"}, 32'(daddr), 32'd0);
        end
    endtask

    // advance one clock edge and apply the same rules to the model
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NUM; i++) mdl[i] = 8'h00;
            dpos = -1;
        end else begin
            if (dpos >= 0) dpos = (dpos == NUM - 1) ? -1 : dpos + 1;
            else if (ds) dpos = 0;
            if (we && !(ZERO && wa == 2'd0)) mdl[wa] = wd;
        end
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input logic [1:0] x, input logic [1:0] y, input logic s);
        we = w; wa = a; wd = d; ra = x; rb = y; ds = s;
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) mdl[i] = 8'hxx;
        // reset, then every index on both ports reads zero
        reset = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            drive(1'b0, 2'd0, 8'h00, 2'(i), 2'(NUM - 1 - i), 1'b0);
            chk("rst_rda", 32'(rad), 32'h0);
            chk("rst_rdb", 32'(rbd), 32'h0);
            chk("rst_valid", 32'(dvalid), 32'h0);
            chk("rst_busy", 32'(dbusy), 32'h0);
        end

        // write 0xA5 to r2 and read it back on both ports
        drive(1'b1, 2'd2, 8'hA5, 2'd0, 2'd1, 1'b0);
        check_all("wr_a5");
        tick();
        drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 1'b0);
        chk("rd_a5_a", 32'(rad), 32'hA5);
        chk("rd_a5_b", 32'(rbd), 32'hA5);

        // same-cycle bypass of 0x3C into r1
        drive(1'b1, 2'd1, 8'h3C, 2'd1, 2'd2, 1'b0);
        chk("byp_3c_a", 32'(rad), 32'h3C);
        chk("byp_3c_b", 32'(rbd), 32'hA5);
        tick();

        // load 0x11..0x44 and dump them
        for (int i = 0; i < NUM; i++) begin
            drive(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 2'(i), 2'd3, 1'b0);
            check_all("load");
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b1);
        check_all("dstart");
        tick();
        for (int k = 0; k < NUM; k++) begin
            // second request mid-dump, and a write to r3 while r3 is dumped
            drive(k == 3, 2'd3, 8'h99, 2'd3, 2'd1, k == 1);
            check_all("dump");
            chk("dump_v_const", 32'(dvalid), 32'h1);
            chk("dump_a_const", 32'(daddr), 32'(k));
            chk("dump_d_const", 32'(ddata), (ZERO && k == 0) ? 32'h0 : 32'(8'h11 * (k + 1)));
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 1'b0);
        chk("post_dump_valid", 32'(dvalid), 32'h0);
        chk("post_dump_busy", 32'(dbusy), 32'h0);
        chk("rd_99", 32'(rad), 32'h99);
        check_all("post_dump");
        tick();

        // reset at dump_addr=1 with a write pending
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
        tick();
        chk("pre_rst_addr", 32'(daddr), 32'h1);
        reset = 1'b1;
        drive(1'b1, 2'd2, 8'h77, 2'd0, 2'd0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
        chk("rst_mid_valid", 32'(dvalid), 32'h0);
        chk("rst_mid_busy", 32'(dbusy), 32'h0);
        chk("rst_mid_addr", 32'(daddr), 32'h0);
        for (int i = 0; i < NUM; i++) begin
            drive(1'b0, 2'd0, 8'h00, 2'(i), 2'(i), 1'b0);
            chk("rst_mid_reg", 32'(rad), 32'h0);
        end

        // writes to r0: ordinary register, or discarded when hardwired
        drive(1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 1'b0);
        chk("r0_same", 32'(rad), ZERO ? 32'h0 : 32'hFF);
        tick();
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b1);
        chk("r0_next", 32'(rad), ZERO ? 32'h0 : 32'hFF);
        tick();
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0);
        chk("r0_dump", 32'(ddata), ZERO ? 32'h0 : 32'hFF);
        check_all("r0_dump_all");
        tick();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
                  2'($urandom), 2'($urandom), $urandom_range(0, 5) == 0);
            check_all("rand");
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
